mem_port_arbiter: RTL and testbench

Shares the processor's single synchronous 512×32 memory between the CPU memory interface (MAR/MDR `Read`/`Write` path) and a debug/loader port.
- Accepts level requests from both sources and arbitrates round-robin on collisions.
- Sequences each access through issue, read-latency wait and acknowledge.
- Sits between DataPath/ControlUnit and the RAM, so program images can be loaded or inspected while the processor runs.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_rr.sv | 27 ++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg: shared state encoding, port-owner codes and RAM latency bounds
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   function automatic logic other_port(input logic port);
      return ~port;
   endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// mem_arb_rr: 2-way round-robin picker; on a collision the last owner loses
// Rev 1.0
// ============================================================================
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic req_cpu,
   input  logic req_dbg,
   input  logic last_owner,
   output logic grant_valid,
   output logic winner
);

   always_comb begin
      grant_valid = req_cpu | req_dbg;
      winner      = OWN_CPU;
      if (req_cpu && req_dbg) begin
         winner = other_port(last_owner);
      end else if (req_dbg) begin
         winner = OWN_DBG;
      end
   end

endmodule : mem_arb_rr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one synchronous RAM between the CPU and a debug
// port; the debug port exists only when MEM_ARB_DBG_EN is defined. Rev 1.0
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   generate
      if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
         $error("mem_port_arbiter: RD_LAT must be within 1..3");
      end
   endgenerate

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

   arb_state_e        state;
   arb_state_e        next_state;
   logic [1:0]        lat_cnt;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              grant_valid;
   logic              winner;
   logic              dbg_req_eff;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              grant;
   logic              rd_done;
   logic              ack_any;

   mem_arb_rr u_rr (
      .req_cpu     (cpu_req),
      .req_dbg     (dbg_req_eff),
      .last_owner  (owner_q),
      .grant_valid (grant_valid),
      .winner      (winner)
   );

`ifdef MEM_ARB_DBG_EN
   logic [DATA_W-1:0] dbg_rdata_q;

   assign dbg_req_eff = dbg_req;

   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (winner == OWN_DBG) begin
         sel_we    = dbg_we;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

   // Owner resets to debug so the CPU wins the first collision.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         owner_q <= OWN_DBG;
      end else if (grant) begin
         owner_q <= winner;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         dbg_rdata_q <= '0;
      end else if (rd_done && owner_q == OWN_DBG) begin
         dbg_rdata_q <= mem_rdata;
      end
   end

   assign dbg_rdata = dbg_rdata_q;
   assign dbg_ack   = ack_any && (owner_q == OWN_DBG);
`else
   logic unused_dbg;

   assign unused_dbg  = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, winner};
   assign dbg_req_eff = 1'b0;
   assign sel_we      = cpu_we;
   assign sel_addr    = cpu_addr;
   assign sel_wdata   = cpu_wdata;
   assign owner_q     = OWN_CPU;
   assign dbg_rdata   = '0;
   assign dbg_ack     = 1'b0;
`endif

   assign grant   = (state == ST_IDLE) && grant_valid;
   assign rd_done = (state == ST_WAIT) && (lat_cnt == LAT_LAST);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      busy       = 1'b1;
      ack_any    = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (grant_valid) begin
               next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_en     = 1'b1;
            mem_we     = we_q;
            next_state = we_q ? ST_ACK : ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_cnt == LAT_LAST) begin
               next_state = ST_ACK;
            end
         end
         ST_ACK: begin
            ack_any    = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Request fields are captured at grant so later requester changes are ignored.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         lat_cnt     <= 2'd0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
      end else begin
         lat_cnt <= (state == ST_WAIT) ? lat_cnt + 2'd1 : 2'd0;
         if (grant) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (rd_done && owner_q == OWN_CPU) begin
            cpu_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner     = owner_q;
   assign cpu_ack   = ack_any && (owner_q == OWN_CPU);
   assign cpu_rdata = cpu_rdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed bench for the RAM arbiter (RD_LAT 1 and 3)
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_ARB_DBG_EN
   localparam logic RST_OWNER = 1'b1;
`else
   localparam logic RST_OWNER = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
   logic [8:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0, cpu_rdata;
   logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_ack;
   logic [8:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0, dbg_rdata;
   logic        mem_en, mem_we, busy, owner;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        c3_req = 1'b0, c3_we = 1'b0, c3_ack;
   logic [8:0]  c3_addr = '0;
   logic [31:0] c3_wdata = '0, c3_rdata;
   logic        d3_ack;
   logic [31:0] d3_rdata;
   logic        m3_en, m3_we, c3_busy, c3_owner;
   logic [8:0]  m3_addr;
   logic [31:0] m3_wdata, m3_rdata;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut1 (
      .Clock(Clock), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut3 (
      .Clock(Clock), .Reset(Reset),
      .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
      .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(9'h000), .dbg_wdata(32'h0),
      .dbg_rdata(d3_rdata), .dbg_ack(d3_ack),
      .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
      .mem_rdata(m3_rdata), .busy(c3_busy), .owner(c3_owner)
   );

   // RAM models: 1-cycle and 3-cycle read pipelines
   logic [31:0] ram1 [512];
   logic [31:0] rd1;
   always @(posedge Clock) begin
      if (mem_en) begin
         if (mem_we) ram1[mem_addr] <= mem_wdata;
         rd1 <= ram1[mem_addr];
      end
   end
   assign mem_rdata = rd1;

   logic [31:0] ram3 [512];
   logic [31:0] rd3 [3];
   always @(posedge Clock) begin
      if (m3_en) begin
         if (m3_we) ram3[m3_addr] <= m3_wdata;
         rd3[0] <= ram3[m3_addr];
      end
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end
   assign m3_rdata = rd3[2];

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full single-requester CPU transaction on dut1, starting in an IDLE cycle.
   task automatic cpu_txn(input logic we, input logic [8:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      tick();
      chk("txn_issue_en", mem_en, 1);
      chk("txn_issue_addr", mem_addr, a);
      tick();
      if (!we) begin
         chk("txn_wait_noack", cpu_ack, 0);
         tick();
      end
      chk("txn_ack", cpu_ack, 1);
      chk("txn_dbg_noack", dbg_ack, 0);
      if (!we) chk("txn_rdata", cpu_rdata, exp);
      cpu_req = 1'b0;
      tick();
      chk("txn_idle", busy, 0);
   endtask

   initial begin
`ifndef MEM_ARB_DBG_EN
      // Debug inputs held active; they must have no effect in this build.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h005; dbg_wdata = 32'h0BAD_0BAD;
`endif
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_owner", owner, RST_OWNER);
      Reset = 1'b1;
      tick();

      // CPU write 0xDEADBEEF to 0x05
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF;
      chk("wr_c0_busy", busy, 0);
      tick();
      chk("wr_c1_en", mem_en, 1);
      chk("wr_c1_we", mem_we, 1);
      chk("wr_c1_addr", mem_addr, 9'h005);
      chk("wr_c1_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_c1_noack", cpu_ack, 0);
      chk("wr_c1_busy", busy, 1);
      chk("wr_c1_owner", owner, 0);
      tick();
      chk("wr_c2_ack", cpu_ack, 1);
      chk("wr_c2_en", mem_en, 0);
      chk("wr_c2_dbg_ack", dbg_ack, 0);
      cpu_req = 1'b0;
      tick();
      chk("wr_c3_busy", busy, 0);
      chk("wr_c3_ack", cpu_ack, 0);

      // CPU read of 0x05; address changes after grant are ignored
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005; cpu_wdata = 32'h0;
      tick();
      chk("rd_c1_en", mem_en, 1);
      chk("rd_c1_we", mem_we, 0);
      chk("rd_c1_addr", mem_addr, 9'h005);
      cpu_addr = 9'h007;
      tick();
      chk("rd_c2_noack", cpu_ack, 0);
      chk("rd_c2_busy", busy, 1);
      chk("rd_c2_addr_held", mem_addr, 9'h005);
      tick();
      chk("rd_c3_ack", cpu_ack, 1);
      chk("rd_c3_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("rd_c3_dbg_rdata", dbg_rdata, 0);
      cpu_req = 1'b0; cpu_addr = 9'h005;
      tick();
      chk("rd_c4_ack", cpu_ack, 0);
      chk("rd_c4_busy", busy, 0);
      chk("rd_c4_hold", cpu_rdata, 32'hDEADBEEF);

      // RD_LAT=3 instance: write then read, ack in cycle 5
      c3_req = 1'b1; c3_we = 1'b1; c3_addr = 9'h005; c3_wdata = 32'hDEADBEEF;
      tick();
      chk("l3_wr_c1_we", m3_we, 1);
      tick();
      chk("l3_wr_c2_ack", c3_ack, 1);
      c3_req = 1'b0;
      tick();
      chk("l3_wr_c3_busy", c3_busy, 0);
      c3_req = 1'b1; c3_we = 1'b0;
      tick();
      chk("l3_rd_c1_en", m3_en, 1);
      chk("l3_rd_c1_we", m3_we, 0);
      tick();
      chk("l3_rd_c2_noack", c3_ack, 0);
      tick();
      chk("l3_rd_c3_noack", c3_ack, 0);
      tick();
      chk("l3_rd_c4_noack", c3_ack, 0);
      chk("l3_rd_c4_busy", c3_busy, 1);
      tick();
      chk("l3_rd_c5_ack", c3_ack, 1);
      chk("l3_rd_c5_rdata", c3_rdata, 32'hDEADBEEF);
      c3_req = 1'b0;
      tick();
      chk("l3_rd_c6_busy", c3_busy, 0);
      chk("l3_rd_c6_ack", c3_ack, 0);

      // Preload collision addresses through the CPU path
      cpu_txn(1'b1, 9'h010, 32'hA1A1A1A1, 32'h0);
      cpu_txn(1'b1, 9'h020, 32'hB2B2B2B2, 32'h0);
      cpu_txn(1'b0, 9'h010, 32'h0, 32'hA1A1A1A1);

`ifdef MEM_ARB_DBG_EN
      // Collision from reset: grants alternate CPU, debug, CPU, debug
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      chk("col_rst_owner", owner, 1);
      chk("col_rst_rdata", cpu_rdata, 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("col_issue_owner", owner, (g % 2 == 1) ? 32'd1 : 32'd0);
         chk("col_issue_addr", mem_addr, (g % 2 == 1) ? 32'h020 : 32'h010);
         chk("col_issue_en", mem_en, 1);
         tick();
         chk("col_wait_busy", busy, 1);
         tick();
         chk("col_cpu_ack", cpu_ack, (g % 2 == 1) ? 32'd0 : 32'd1);
         chk("col_dbg_ack", dbg_ack, (g % 2 == 1) ? 32'd1 : 32'd0);
         chk("col_cpu_rdata", cpu_rdata, 32'hA1A1A1A1);
         chk("col_dbg_rdata", dbg_rdata, (g == 0) ? 32'h0 : 32'hB2B2B2B2);
         if (g == 3) begin
            cpu_req = 1'b0;
            dbg_req = 1'b0;
         end
         tick();
         chk("col_idle_busy", busy, (g == 3) ? 32'd0 : 32'd0);
      end

      // Debug write to 0x1FF, then CPU read of 0x1FF
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h1FF; dbg_wdata = 32'h12345678;
      tick();
      chk("dbgwr_c1_we", mem_we, 1);
      chk("dbgwr_c1_addr", mem_addr, 9'h1FF);
      chk("dbgwr_c1_wdata", mem_wdata, 32'h12345678);
      chk("dbgwr_c1_owner", owner, 1);
      tick();
      chk("dbgwr_c2_ack", dbg_ack, 1);
      chk("dbgwr_c2_cpu_ack", cpu_ack, 0);
      dbg_req = 1'b0;
      tick();
      chk("dbgwr_c3_busy", busy, 0);
      cpu_txn(1'b0, 9'h1FF, 32'h0, 32'h12345678);
`else
      chk("nodbg_owner", owner, 0);
      chk("nodbg_rdata", dbg_rdata, 0);
      cpu_txn(1'b0, 9'h005, 32'h0, 32'hDEADBEEF);
`endif

      // Reset asserted in the WAIT cycle of a read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
      tick();
      chk("abort_c1_en", mem_en, 1);
      tick();
      chk("abort_c2_busy", busy, 1);
      Reset = 1'b0;
      cpu_req = 1'b0;
      tick();
      chk("abort_c3_busy", busy, 0);
      chk("abort_c3_ack", cpu_ack, 0);
      chk("abort_c3_rdata", cpu_rdata, 0);
      Reset = 1'b1;
      tick();
      chk("abort_c4_ack", cpu_ack, 0);
      chk("abort_c4_busy", busy, 0);
      cpu_txn(1'b0, 9'h005, 32'h0, 32'hDEADBEEF);
      chk("final_dbg_ack", dbg_ack, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire
